// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit single-stage processor:
// opcodes, sequencer states and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SLLI = 3'b001,
    OP_J    = 3'b010,
    OP_BLT  = 3'b100,
    OP_ADDI = 3'b101
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int OP_W    = 3;
  localparam int JOFF_HI = 4;
  localparam int JOFF_W  = 5;
  localparam int BOFF_HI = 2;
  localparam int BOFF_W  = 3;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Next-PC resolution for J / BLT and detection of the
// J-to-self halt idiom. Purely combinational.
module next_pc
  import cpu_pkg::*;
#(
  parameter int Psize = 8,
  parameter int Isize = 8
) (
  input  logic [Psize-1:0] pc,
  input  logic [Isize-1:0] instr,
  input  logic             lt,
  output logic [Psize-1:0] target,
  output logic             halt_idiom
);

  logic [OP_W-1:0]  op;
  logic [Psize-1:0] one;
  logic [Psize-1:0] jofs;
  logic [Psize-1:0] bofs;
  logic             is_j;
  logic             is_blt;

  assign op     = instr[Isize-1 -: OP_W];
  assign one    = {{(Psize-1){1'b0}}, 1'b1};
  assign is_j   = (op == OP_J);
  assign is_blt = (op == OP_BLT);

  assign jofs = {{(Psize-JOFF_W){instr[JOFF_HI]}},
                 instr[JOFF_HI:0]};
  assign bofs = {{(Psize-BOFF_W){1'b0}},
                 instr[BOFF_HI:0]};

  // Adder wraps modulo 2^Psize, so negative jumps fall out naturally.
  always_comb begin
    target     = pc + one;
    halt_idiom = 1'b0;
    unique case (1'b1)
      is_j: begin
        target     = pc + jofs;
        halt_idiom = (instr[JOFF_HI:0] == '0);
      end
      is_blt: begin
        target = lt ? (pc + bofs) : (pc + one);
      end
      default: begin
        target = pc + one;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, run/pause/step/halt controller and
// saturating retired-instruction counter.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int Psize = 8,
  parameter int Isize = 8,
  parameter int Csize = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             run,
  input  logic             step,
  input  logic             restart,
  input  logic [Isize-1:0] I,
  input  logic             lt,
  output logic [Psize-1:0] address,
  output logic             exec_en,
  output logic             halted,
  output logic [Csize-1:0] icount
);

  state_t           state;
  state_t           nstate;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] target;
  logic             halt_idiom;
  logic             rewind;
  logic [Csize-1:0] cnt;

  next_pc #(
    .Psize(Psize),
    .Isize(Isize)
  ) u_next_pc (
    .pc        (pc),
    .instr     (I),
    .lt        (lt),
    .target    (target),
    .halt_idiom(halt_idiom)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE, S_PAUSE: begin
        if (restart)   nstate = S_IDLE;
        else if (run)  nstate = S_RUN;
        else if (step) nstate = S_STEP;
      end
      S_RUN: begin
        if (halt_idiom) nstate = S_HALT;
        else if (!run)  nstate = S_PAUSE;
        else            nstate = S_RUN;
      end
      S_STEP: begin
        if (halt_idiom) nstate = S_HALT;
        else            nstate = S_PAUSE;
      end
      S_HALT: begin
        if (restart) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    exec_en = 1'b0;
    halted  = 1'b0;
    unique case (state)
      S_RUN, S_STEP: exec_en = 1'b1;
      S_HALT:        halted  = 1'b1;
      default: begin
        exec_en = 1'b0;
        halted  = 1'b0;
      end
    endcase
  end

  // restart only acts in the stopped states; RUN/STEP ignore it.
  assign rewind = restart && !exec_en;

  always_ff @(posedge Clock) begin
    if (Reset)        pc <= '0;
    else if (rewind)  pc <= '0;
    else if (exec_en) pc <= target;
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      cnt <= '0;
    else if (exec_en && !(&cnt))
      cnt <= cnt + {{(Csize-1){1'b0}}, 1'b1};
  end

  assign address = pc;
  assign icount  = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer with an in-bench
// behavioural model plus directed pinning checks.
module tb_pc_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_HALT  = 4;

  logic        Clock = 1'b0;
  logic        Reset, run, step, restart, lt;
  logic [7:0]  I, I4, address, address4;
  logic        exec_en, halted, exec_en4, halted4;
  logic [15:0] icount;
  logic [3:0]  icount4;
  logic [7:0]  prog [256];

  int errors = 0;
  int checks = 0;
  bit live = 0;

  int m_st = M_IDLE;
  int m_pc = 0;
  int m_cnt = 0;

  assign I  = prog[address];
  assign I4 = prog[address4];

  always #5 Clock = ~Clock;

  pc_sequencer dut (
    .Clock(Clock), .Reset(Reset), .run(run), .step(step),
    .restart(restart), .I(I), .lt(lt), .address(address),
    .exec_en(exec_en), .halted(halted), .icount(icount)
  );

  pc_sequencer #(.Csize(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .run(run), .step(step),
    .restart(restart), .I(I4), .lt(lt), .address(address4),
    .exec_en(exec_en4), .halted(halted4), .icount(icount4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
    #1;
  endtask

  // Behavioural model: what one clock edge does, from the rules.
  always @(posedge Clock) begin
    logic [7:0] ins;
    int off;
    bit hlt;
    if (Reset) begin
      m_st = M_IDLE; m_pc = 0; m_cnt = 0;
    end else if (m_st == M_RUN || m_st == M_STEP) begin
      ins = prog[m_pc];
      hlt = 0;
      case (ins[7:5])
        3'b010: begin
          off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
          hlt = (off == 0);
          m_pc = (m_pc + off) & 255;
        end
        3'b100: m_pc = (m_pc + (lt ? int'(ins[2:0]) : 1)) & 255;
        default: m_pc = (m_pc + 1) & 255;
      endcase
      m_cnt++;
      if (hlt) m_st = M_HALT;
      else if (m_st == M_RUN && run) m_st = M_RUN;
      else m_st = M_PAUSE;
    end else if (m_st == M_HALT) begin
      if (restart) begin m_st = M_IDLE; m_pc = 0; end
    end else begin
      if (restart) begin m_st = M_IDLE; m_pc = 0; end
      else if (run) m_st = M_RUN;
      else if (step) m_st = M_STEP;
    end
  end

  always @(negedge Clock) begin
    if (live) begin
      chk("address", address, m_pc);
      chk("exec_en", exec_en,
          (m_st == M_RUN || m_st == M_STEP) ? 1 : 0);
      chk("halted", halted, (m_st == M_HALT) ? 1 : 0);
      chk("icount", icount, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("address4", address4, m_pc);
      chk("icount4", icount4, (m_cnt > 15) ? 15 : m_cnt);
    end
  end

  initial begin
    Reset = 1; run = 0; step = 0; restart = 0; lt = 0;
    for (int a = 0; a < 256; a++) prog[a] = 8'h00;
    cyc(); cyc();
    live = 1;
    chk("rst_addr", address, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_halt", halted, 0);
    chk("rst_cnt", icount, 0);

    Reset = 0; run = 1;
    cyc();
    repeat (257) cyc();
    chk("wrap_cnt", icount, 257);
    chk("wrap_addr", address, 1);
    chk("sat4", icount4, 15);
    run = 0;
    cyc();
    chk("pause_exec", exec_en, 0);
    chk("pause_addr", address, 2);
    chk("pause_cnt", icount, 258);

    prog[2] = 8'h95; prog[6] = 8'h5C; prog[9] = 8'h40;
    restart = 1; cyc(); restart = 0;
    chk("restart_addr", address, 0);
    run = 1; lt = 0;
    cyc();
    repeat (3) cyc();
    chk("blt_nt", address, 3);
    repeat (4) cyc();
    chk("j_back", address, 2);
    lt = 1;
    cyc();
    chk("blt_t", address, 7);
    cyc(); cyc();
    chk("selfj_addr", address, 9);
    chk("selfj_exec", exec_en, 1);
    cyc();
    chk("halt_set", halted, 1);
    chk("halt_addr", address, 9);
    chk("halt_exec", exec_en, 0);
    step = 1; cyc(); step = 0; cyc();
    chk("halt_hold", address, 9);
    chk("halt_stay", halted, 1);
    run = 0; restart = 1; cyc(); restart = 0;
    chk("unhalt_addr", address, 0);
    chk("unhalt_flag", halted, 0);

    lt = 0;
    repeat (4) begin
      step = 1; cyc(); step = 0; cyc();
    end
    chk("step_at4", address, 4);
    chk("step_cnt0", icount, 273);
    step = 1; cyc(); step = 0;
    chk("step_exec", exec_en, 1);
    cyc();
    chk("step_addr", address, 5);
    chk("step_once", exec_en, 0);
    chk("step_cnt", icount, 274);
    run = 1; step = 1; cyc(); step = 0;
    cyc();
    chk("runwins", exec_en, 1);

    for (int a = 0; a < 256; a++) prog[a] = 8'h00;
    for (int k = 0; k < 400 && m_pc != 30; k++) cyc();
    chk("mid_addr", address, 30);
    Reset = 1; cyc(); Reset = 0;
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_exec", exec_en, 0);
    chk("mid_rst_cnt", icount, 0);

    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        for (int a = 0; a < 256; a++) begin
          prog[a] = 8'($urandom);
          if (prog[a][7:5] == 3'b010 && prog[a][4:0] == 5'd0
              && $urandom_range(0, 3) != 0)
            prog[a][0] = 1'b1;
        end
      end
      run     = ($urandom_range(0, 3) != 0);
      step    = ($urandom_range(0, 5) == 0);
      restart = ($urandom_range(0, 15) == 0);
      lt      = 1'($urandom);
      Reset   = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
